// File: rtl/addsub_pkg.sv
// +------------------------------------------------------------------------+
// | addsub_pkg: shared state encoding, opcodes and size limits for the     |
// | byte-serial add/sub sequencer.                       Rev 1.0           |
// +------------------------------------------------------------------------+
`default_nettype none

package addsub_pkg;

  localparam int NBYTE_MIN = 2;
  localparam int NBYTE_MAX = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : addsub_pkg

`default_nettype wire

// File: rtl/add8_unit.sv
// +------------------------------------------------------------------------+
// | add8_unit: combinational 8-bit ripple-carry adder of full-adder cells, |
// | also exporting the carry into bit 7.                 Rev 1.0           |
// +------------------------------------------------------------------------+
`default_nettype none

module add8_unit (
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  logic       ci_i,
  output logic [7:0] sum_o,
  output logic       co_o,
  output logic       c7_o
);

  logic [8:0] w_c;

  assign w_c[0] = ci_i;

  for (genvar gi = 0; gi < 8; gi++) begin : g_fa
    assign sum_o[gi]  = x_i[gi] ^ y_i[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (x_i[gi] & y_i[gi]) | (w_c[gi] & (x_i[gi] ^ y_i[gi]));
  end

  assign co_o = w_c[8];
  assign c7_o = w_c[7];

endmodule : add8_unit

`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
// +------------------------------------------------------------------------+
// | addsub_seq_ctrl: 8*NBYTE-bit add/sub run LSB-first through one shared  |
// | 8-bit adder. Optional signed overflow output under ADDSUB_OVF_EN.      |
// |                                                      Rev 1.0           |
// +------------------------------------------------------------------------+
`default_nettype none

module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int NBYTE = 4  // legal NBYTE_MIN..NBYTE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               op_i,
  input  logic [8*NBYTE-1:0] a_i,
  input  logic [8*NBYTE-1:0] b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [8*NBYTE-1:0] s_o,
  output logic               co_o
`ifdef ADDSUB_OVF_EN
 ,output logic               ovf_o
`endif
);

  localparam int W     = 8 * NBYTE;
  localparam int IDX_W = $clog2(NBYTE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTE - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     ra_q, ra_d;
  logic [W-1:0]     rb_q, rb_d;
  logic [W-1:0]     s_q, s_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [7:0] w_x, w_y, w_sum;
  logic       w_co, w_c7;

  assign w_x = ra_q[{idx_q, 3'b000} +: 8];
  assign w_y = rb_q[{idx_q, 3'b000} +: 8];

  add8_unit u_add8 (
    .x_i   (w_x),
    .y_i   (w_y),
    .ci_i  (cy_q),
    .sum_o (w_sum),
    .co_o  (w_co),
    .c7_o  (w_c7)
  );

`ifndef ADDSUB_OVF_EN
  logic unused_c7;
  assign unused_c7 = w_c7;
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    s_d     = s_q;
    cy_d    = cy_q;
    co_d    = co_q;
    idx_d   = idx_q;
`ifdef ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Subtract is a + ~b + 1: invert b here, seed the carry with op.
          ra_d    = a_i;
          rb_d    = (op_i == OP_SUB) ? ~b_i : b_i;
          cy_d    = op_i;
          idx_d   = '0;
          s_d     = '0;
          co_d    = 1'b0;
`ifdef ADDSUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[{idx_q, 3'b000} +: 8] = w_sum;
        cy_d  = w_co;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          co_d    = w_co;
`ifdef ADDSUB_OVF_EN
          ovf_d   = w_c7 ^ w_co;
`endif
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      s_q     <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      s_q     <= s_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done_o = (state_q == ST_DONE);
  assign s_o    = s_q;
  assign co_o   = co_q;
`ifdef ADDSUB_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule : addsub_seq_ctrl

`default_nettype wire

// File: tb/tb_addsub_seq_ctrl.sv
// +------------------------------------------------------------------------+
// | tb_addsub_seq_ctrl: directed vectors for addsub_seq_ctrl, NBYTE=4.     |
// | ADDSUB_OVF_EN adds the overflow vectors.             Rev 1.0           |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_addsub_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, co;
  logic [31:0] s;
`ifdef ADDSUB_OVF_EN
  logic        ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_seq_ctrl #(.NBYTE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .s_o     (s),
    .co_o    (co)
`ifdef ADDSUB_OVF_EN
   ,.ovf_o   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, busy width, result and the pulse end.
  task automatic run_op(input string tag, input logic o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_s,
                        input logic exp_co, input logic exp_ovf);
    int done_at = 0;
    int busy_n  = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 12 && done_at == 0; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_at = i;
    end
    check({tag, " done_lat"}, done_at, 5);
    check({tag, " busy_cyc"}, busy_n, 5);
    check({tag, " s"}, s, exp_s);
    check({tag, " co"}, {31'd0, co}, {31'd0, exp_co});
`ifdef ADDSUB_OVF_EN
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("note: %s has no overflow expectation", tag);
`endif
    @(negedge clk);
    check({tag, " post_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int done_n;
    int d1_at, d2_at;
    logic [31:0] s1, s2;
    logic        co2;

    repeat (2) @(negedge clk);
    check("rst busy/done", {30'd0, busy, done}, 32'd0);
    check("rst s", s, 32'd0);
    check("rst co", {31'd0, co}, 32'd0);
`ifdef ADDSUB_OVF_EN
    check("rst ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;

    run_op("add_ff_1",   1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0);
    run_op("add_wrap",   1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_5_7",    1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_noborr", 1'b1, 32'h12345678, 32'h02345678, 32'h10000000, 1'b1, 1'b0);

    // Start held high through busy: only one done, then re-accept after it.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h00000010; b = 32'h00000020;
    @(posedge clk);
    #1 a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    d1_at = 0; d2_at = 0; s1 = '0; s2 = '0; co2 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 7) start = 1'b0;
      if (done && d1_at == 0) begin d1_at = i; s1 = s; end
      else if (done && d2_at == 0) begin d2_at = i; s2 = s; co2 = co; end
    end
    check("hold first_done", d1_at, 5);
    check("hold first_s", s1, 32'h00000030);
    check("hold second_done", d2_at, 11);
    check("hold second_s", s2, 32'hFFFFFFFE);
    check("hold second_co", {31'd0, co2}, 32'd1);

    // Reset during the second RUN cycle aborts and clears.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h11111111; b = 32'h22222222;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort partial_s", s, 32'h00000033);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort s", s, 32'd0);
    check("abort co", {31'd0, co}, 32'd0);
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort no_done", done_n, 0);
    run_op("add_3_4", 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

    // rst and start together: start is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_start s", s, 32'd0);

`ifdef ADDSUB_OVF_EN
    run_op("ovf_add", 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
    run_op("ovf_sub", 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op("ovf_none", 1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_addsub_seq_ctrl

`default_nettype wire
